// File: rtl/alu_seq.sv
// alu_seq: ALU with a valid/ready request and result handshake. Most opcodes
// complete in one cycle. MUL is an iterative shift-add multiply that retires
// one multiplier bit per cycle. Results and NZVC flags live in registers.
module alu_seq #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrol,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             negative_reg, zero_reg, overflow_reg, carry_reg;
  logic [WIDTH-1:0] acc_reg, mcand_reg, mplier_reg;
  logic [CW-1:0]    cnt_reg;
  logic             mul_sf_reg;

  logic             accept, mul_start, mul_last, load_single, load_any;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res, mul_sum, load_res;
  logic             alu_v, alu_c, load_v, load_c, load_sf;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (MUL_EN == 1'b1) && (cntrol == 3'b001);
  assign mul_last  = (state_reg == MUL) && (cnt_reg == CNT_LAST);

  // State register; reset also aborts any multiply in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next state: enter MUL on a multiply accept, leave after the last bit
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready only when idle and the result slot is free or being drained now
  always_comb begin
    in_ready = reset_n && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  end

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
  assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Single-cycle opcode result and V/C flags; 001 passes B when no multiplier
  always_comb begin
    alu_res = B;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (cntrol)
      3'b010: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b011: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b100:  alu_res = A & B;
      3'b101:  alu_res = A | B;
      3'b110:  alu_res = A ^ B;
      3'b111:  alu_res = A << B[CW-1:0];
      default: alu_res = B;
    endcase
  end

  // Select what is loaded into the result/flag registers this edge
  always_comb begin
    load_single = accept && !mul_start;
    load_any    = load_single || mul_last;
    load_res    = load_single ? alu_res   : mul_sum;
    load_v      = load_single ? alu_v     : 1'b0;
    load_c      = load_single ? alu_c     : 1'b0;
    load_sf     = load_single ? set_flags : mul_sf_reg;
  end

  // Result slot and flag register; a result drains only on handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      negative_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      carry_reg     <= 1'b0;
    end else if (load_any) begin
      out_valid_reg <= 1'b1;
      result_reg    <= load_res;
      if (load_sf) begin
        negative_reg <= load_res[WIDTH-1];
        zero_reg     <= (load_res == '0);
        overflow_reg <= load_v;
        carry_reg    <= load_c;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Shift-add multiplier: accumulate shifted multiplicand per multiplier bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      mul_sf_reg <= 1'b0;
    end else if (mul_start) begin
      acc_reg    <= '0;
      mcand_reg  <= A;
      mplier_reg <= B;
      cnt_reg    <= '0;
      mul_sf_reg <= set_flags;
    end else if (state_reg == MUL) begin
      acc_reg    <= mul_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign negative  = negative_reg;
  assign zero      = zero_reg;
  assign overflow  = overflow_reg;
  assign carry_out = carry_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus randomized traffic for alu_seq, checked
// against a transaction-level model of results, flags and handshake timing.
module tb_alu_seq;

  localparam int W  = 64;
  localparam int SW = $clog2(W);

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   cntrol = 3'b000;
  logic         set_flags = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         negative, zero, overflow, carry_out;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic         m_ov = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_n = 1'b0, m_z = 1'b0, m_v = 1'b0, m_c = 1'b0;
  int           m_rem = 0;
  logic [W-1:0] p_res = '0;
  logic         p_v = 1'b0, p_c = 1'b0, p_sf = 1'b0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (op_a),
    .B         (op_b),
    .cntrol    (cntrol),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics of every opcode in plain arithmetic
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, output logic [W-1:0] r,
                                 output logic v, output logic c);
    logic signed [W:0] s;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b001: r = a * b;
      3'b010: begin
        r = a + b;
        c = (r < a);
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        v = s[W] ^ s[W-1];
      end
      3'b011: begin
        r = a - b;
        c = (a >= b);
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        v = s[W] ^ s[W-1];
      end
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      3'b111:  r = a << (b % W);
      default: r = b;
    endcase
  endfunction

  task automatic model_flags(input logic [W-1:0] r, input logic v, input logic c);
    m_n = r[W-1];
    m_z = (r == '0);
    m_v = v;
    m_c = c;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_out_valid"}, out_valid, m_ov);
    check_val({tag, "_result"}, result, m_res);
    check_val({tag, "_flags"}, {negative, zero, overflow, carry_out}, {m_n, m_z, m_v, m_c});
  endtask

  // One clock cycle: drive at negedge, check ready, advance model after posedge
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic sf, input logic ordy);
    logic         exp_rdy, acc, rv, rc;
    logic [W-1:0] r;
    @(negedge clk);
    in_valid  = v;
    op_a      = a;
    op_b      = b;
    cntrol    = op;
    set_flags = sf;
    out_ready = ordy;
    #1;
    exp_rdy = (m_rem == 0) && (!m_ov || ordy);
    check_val("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (acc) begin
      ref_op(a, b, op, r, rv, rc);
      $display("txn op=%0d A=%h B=%h set_flags=%0d expect=%h", op, a, b, sf, r);
      if (op == 3'b001) begin
        m_rem = W;
        p_res = r;
        p_v   = rv;
        p_c   = rc;
        p_sf  = sf;
        m_ov  = 1'b0;
      end else begin
        m_ov  = 1'b1;
        m_res = r;
        if (sf) model_flags(r, rv, rc);
      end
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_ov  = 1'b1;
        m_res = p_res;
        if (p_sf) model_flags(p_res, p_v, p_c);
      end
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    check_outputs("cyc");
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_result", result, '0);
    check_val("rst_flags", {negative, zero, overflow, carry_out}, 4'b0000);
    check_val("rst_in_ready", in_ready, 1'b0);
    m_ov  = 1'b0;
    m_res = '0;
    m_n = 1'b0; m_z = 1'b0; m_v = 1'b0; m_c = 1'b0;
    m_rem = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_val("rel_in_ready", in_ready, 1'b1);
    $display("txn reset");
  endtask

  function automatic logic [W-1:0] pick_val();
    logic [63:0] t;
    case ($urandom_range(0, 7))
      0:       t = '0;
      1:       t = '1;
      2:       t = 64'h8000_0000_0000_0000;
      3:       t = 64'h7FFF_FFFF_FFFF_FFFF;
      4:       t = 64'($urandom_range(0, 255));
      default: t = {$urandom(), $urandom()};
    endcase
    return t[W-1:0];
  endfunction

  initial begin
    int lat;
    logic [2:0] rop;
    do_reset();

    // ADD signed overflow
    cycle(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1'b1, 1'b1);
    check_val("add_ovf_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("add_ovf_nzvc", {negative, zero, overflow, carry_out}, 4'b1010);

    // SUB signed overflow, then equal operands
    cycle(1'b1, 64'h8000_0000_0000_0000, 64'd12353, 3'b011, 1'b1, 1'b1);
    check_val("sub_ovf_res", result, 64'h7FFF_FFFF_FFFF_CFBF);
    check_val("sub_ovf_nzvc", {negative, zero, overflow, carry_out}, 4'b0011);
    cycle(1'b1, 64'd5, 64'd5, 3'b011, 1'b1, 1'b1);
    check_val("sub_eq_res", result, 64'd0);
    check_val("sub_eq_nzvc", {negative, zero, overflow, carry_out}, 4'b0101);

    // MUL latency, result and untouched flags
    cycle(1'b1, 64'd3, 64'd5, 3'b001, 1'b0, 1'b1);
    lat = 0;
    do begin
      cycle(1'b0, '0, '0, 3'b000, 1'b0, 1'b0);
      lat++;
    end while (!out_valid && lat < 100);
    check_val("mul_latency", 64'(lat), 64'd64);
    check_val("mul_res", result, 64'd15);
    check_val("mul_nzvc", {negative, zero, overflow, carry_out}, 4'b0101);

    // Backpressure then back-to-back drain
    cycle(1'b1, 64'hF0F0, 64'hFF00, 3'b110, 1'b1, 1'b1);
    check_val("xor_res", result, 64'h0FF0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'h1234, 64'h5678, 3'b100, 1'b1, 1'b0);
      check_val("bp_hold_res", result, 64'h0FF0);
      check_val("bp_in_ready", in_ready, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 64'(i), 64'd100, 3'b010, 1'b0, 1'b1);
      check_val("b2b_res", result, 64'(i + 100));
      check_val("b2b_valid", out_valid, 1'b1);
    end
    cycle(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
    check_val("drain_valid", out_valid, 1'b0);

    // Reset in the middle of a multiply
    cycle(1'b1, 64'd7, 64'd9, 3'b001, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
      if (out_valid) check_val("abort_valid", out_valid, 1'b0);
    end
    check_val("abort_idle_valid", out_valid, 1'b0);
    cycle(1'b1, 64'd1, 64'd1, 3'b010, 1'b1, 1'b0);
    check_val("post_rst_add", result, 64'd2);

    // Reset with a pending result
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'b001 && $urandom_range(0, 3) != 0) rop = 3'b011;
      cycle($urandom_range(0, 3) != 0, pick_val(), pick_val(), rop,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 64, datapath width in bits (legal values 8..64, power of two).
REQ-002 Parameter: MUL_EN, 1, when 1 opcode 001 is an iterative multiply; when 0 opcode 001 behaves as 000 (pass B).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low; synchronous release.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 cntrol  input  3  opcode: 000 pass B, 001 MUL, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 LSL (A shifted left by B[log2(WIDTH)-1:0]).
REQ-009 set_flags  input  1  when high at accept, operation updates the flag register.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 negative, zero, overflow, carry_out  output  1 each  registered NZVC flag register.

Function
REQ-014 Accept occurs on a rising edge with in_valid && in_ready; A, B, cntrol, set_flags captured then, later input changes ignored.
REQ-015 in_ready = (state == IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-016 States: IDLE, MUL; IDLE->MUL on accept of opcode 001 with MUL_EN=1; MUL->IDLE after exactly WIDTH iteration cycles, loading result.
REQ-017 Single-cycle opcodes: accepted at edge N, out_valid=1 and result valid after edge N (latency 1), full throughput of one op per cycle.
REQ-018 MUL: shift-add, one multiplier bit per cycle; result = low WIDTH bits of A*B (unsigned); out_valid rises WIDTH cycles after accept; in_ready=0 throughout.
REQ-019 ADD: result = A+B mod 2^WIDTH; carry_out = carry from bit WIDTH-1; overflow = signed overflow (operands same sign, result sign differs).
REQ-020 SUB: computed as A + ~B + 1; carry_out = 1 when no borrow (A >= B unsigned); overflow = signed overflow of A-B.
REQ-021 AND/OR/XOR/pass/LSL/MUL: carry_out=0, overflow=0 when flags updated.
REQ-022 negative = result[WIDTH-1], zero = (result == 0), for every opcode.
REQ-023 Flag register loads at the edge result is loaded, only if captured set_flags=1; otherwise all four flags hold previous value.
REQ-024 result and out_valid hold stable while out_valid && !out_ready; result cleared to no value change after handshake (holds last value, out_valid drops).
REQ-025 Simultaneous out handshake and new accept in same cycle: old result consumed, new result loaded next edge, out_valid stays 1.
REQ-026 in_valid while in_ready=0: no capture, no side effect; requester must hold.

Reset
REQ-027 reset_n=0 forces immediately: state IDLE, out_valid=0, result=0, all flags=0, multiply accumulator and counter=0.
REQ-028 Reset mid-multiply aborts the operation; no result produced after release.
REQ-029 in_ready=0 while reset_n=0; in_ready=1 first cycle after release.

Verification
REQ-030 Reset: assert reset_n=0 mid-cycle with out_valid=1 -> out_valid, result, NZVC all 0 without waiting for clk edge.
REQ-031 ADD overflow (WIDTH=64): A=7FFF_FFFF_FFFF_FFFF, B=7FFF_FFFF_FFFF_FFFF, cntrol=010, set_flags=1 -> next cycle result=FFFF_FFFF_FFFF_FFFE, N=1 Z=0 V=1 C=0.
REQ-032 SUB overflow: A=8000_0000_0000_0000, B=12353, cntrol=011, set_flags=1 -> result=7FFF_FFFF_FFFF_CFBF, N=0 Z=0 V=1 C=1; then A=B=5 SUB -> result 0, Z=1 C=1.
REQ-033 MUL: A=3, B=5, cntrol=001, set_flags=0 -> in_ready=0 for 64 cycles, result=15 with out_valid 64 cycles after accept, flags unchanged from prior op.
REQ-034 Backpressure: out_ready=0, issue XOR A=F0F0, B=FF00 -> result 0F F0 (00F0... =0x0FF0) held stable, in_ready=0; raise out_ready with in_valid high -> back-to-back results, one per cycle, no loss or duplication.
REQ-035 Reset mid-multiply: reset_n=0 at cycle 10 of MUL, release -> out_valid stays 0, in_ready=1, subsequent ADD 1+1 -> result 2.
